// File: rtl/uart_pkg.sv
// Shared constants and receiver state encoding for the UART receive and transmit paths.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned SC_W       = $clog2(OVERSAMPLE);
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BI_W       = $clog2(BYTE_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO with a registered head, count and full flag.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = BYTE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, full_q;
  logic             do_push_c, do_pop_c;

  // A push into a full FIFO only lands when a pop frees the slot in the same cycle.
  always_comb begin
    do_pop_c  = pop_i && valid_q;
    do_push_c = push_i && (!full_q || do_pop_c);
    wr_ptr_d  = wr_ptr_q + PTR_W'(do_push_c);
    rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop_c);
    count_d   = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    head_d    = head_q;
    if (do_pop_c) begin
      if (count_q == CNT_W'(1)) begin
        if (do_push_c) head_d = push_data_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end else if (!valid_q && do_push_c) begin
      head_d = push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign data_o  = head_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a FWFT byte FIFO drained by valid/ready.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic              rx_meta_q, rx_s_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic              tick_c;
  rx_state_t         state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic [BI_W-1:0]   bi_q, bi_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d;
  logic              push_c, pop_c, fifo_full;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  // Two-flop synchroniser; idle-high so reset must not fake a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running oversample tick; never re-phased by the receiver.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_cnt_q <= '0;
    else if (div_cnt_q == DIV_W'(DIV - 1)) div_cnt_q <= '0;
    else div_cnt_q <= div_cnt_q + DIV_W'(1);
  end

  assign tick_c = (div_cnt_q == DIV_W'(DIV - 1));

  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    bi_d        = bi_q;
    shreg_d     = shreg_q;
    push_c      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          sc_d    = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_c) begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == SC_W'(MID_SAMPLE)) begin
            if (!rx_s_q) begin
              sc_d    = '0;
              bi_d    = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == SC_W'(OVERSAMPLE - 1)) begin
            shreg_d = {rx_s_q, shreg_q[BYTE_W-1:1]};
            if (bi_q == BI_W'(BYTE_W - 1)) state_d = STOP;
            else bi_d = bi_q + BI_W'(1);
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == SC_W'(OVERSAMPLE - 1)) begin
            if (rx_s_q) begin
              push_c  = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = BREAK;
            end
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop_c     = rx_valid && rx_ready;
  assign overrun_d = push_c && fifo_full && !pop_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sc_q        <= '0;
      bi_q        <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      bi_q        <= bi_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_c),
    .push_data_i (shreg_q),
    .pop_i       (pop_c),
    .data_o      (rx_data),
    .valid_o     (rx_valid),
    .full_o      (fifo_full),
    .count_o     (level)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial stimulus, queue-based reference model, decoupled monitor.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_FREQ = 96_000_000;
  localparam int unsigned BAUD     = 1_000_000;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned BIT      = CLK_FREQ / BAUD;

  logic                   clk      = 1'b0;
  logic                   reset    = 1'b0;
  logic                   rx       = 1'b1;
  logic                   rx_ready = 1'b0;
  logic [7:0]             rx_data;
  logic                   rx_valid;
  logic                   frame_err;
  logic                   overrun;
  logic [$clog2(DEPTH):0] level;

  int total = 0;
  int bad   = 0;
  byte unsigned exp_q[$];
  int fe_seen = 0, ov_seen = 0, fe_exp = 0, ov_exp = 0;
  bit rand_ready = 1'b0;
  bit prev_fe = 1'b0, prev_ov = 1'b0;

  uart_rx_fifo #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and tallies status pulses.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got data 0x%0h while model holds no byte", rx_data);
        end else begin
          chk("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err) begin
        fe_seen++;
        chk("frame_err_width", 32'(prev_fe), 32'd0);
      end
      if (overrun) begin
        ov_seen++;
        chk("overrun_width", 32'(prev_ov), 32'd0);
      end
      prev_fe = frame_err;
      prev_ov = overrun;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) rx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: a good byte is kept unless the FIFO is full and nothing leaves that cycle.
  task automatic model_frame(input byte unsigned b, input bit stop_ok, input bit pop_at_push);
    if (!stop_ok) fe_exp++;
    else if (exp_q.size() >= DEPTH && !pop_at_push) ov_exp++;
    else exp_q.push_back(b);
  endtask

  // Drives one 8N1 frame; the line is left at the stop-bit value.
  task automatic send_frame(input byte unsigned b, input bit stop_val);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_val;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input byte unsigned b);
    model_frame(b, 1'b1, 1'b0);
    send_frame(b, 1'b1);
    repeat (BIT / 2) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag, input bit check_level);
    repeat (20) @(negedge clk);
    if (check_level) chk({tag, "_level"}, 32'(level), 32'(exp_q.size()));
    chk({tag, "_frame_err_count"}, 32'(fe_seen), 32'(fe_exp));
    chk({tag, "_overrun_count"}, 32'(ov_seen), 32'(ov_exp));
  endtask

  task automatic drain(input string tag);
    rx_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_drain_queue"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_drain_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    bit found;

    repeat (5) @(negedge clk);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_data", 32'(rx_data), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Single byte held in the FIFO, then drained.
    send_byte(8'h55);
    chk("single_valid", 32'(rx_valid), 32'd1);
    chk("single_head", 32'(rx_data), 32'h55);
    checkpoint("single", 1'b1);
    drain("single");

    // Short low pulse must be rejected as a glitch.
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checkpoint("glitch", 1'b1);
    send_byte(8'hA3);
    checkpoint("after_glitch", 1'b1);
    drain("after_glitch");

    // Framing error followed by a held-low line.
    model_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
    checkpoint("framing", 1'b1);
    send_byte(8'h81);
    drain("after_framing");
    checkpoint("after_framing", 1'b1);

    // Overrun: nine bytes into an eight-deep FIFO with the consumer stalled.
    rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'(i));
    checkpoint("overrun", 1'b1);

    // Full FIFO with a pop landing on the push cycle.
    found = 1'b0;
    model_frame(8'hEE, 1'b1, 1'b1);
    fork
      send_frame(8'hEE, 1'b1);
      begin
        for (int i = 0; i < 12 * BIT && !found; i++) begin
          @(negedge clk);
          if (dut.push_c) begin
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
            found = 1'b1;
          end
        end
      end
    join
    chk("push_pop_seen", 32'(found), 32'd1);
    checkpoint("push_pop", 1'b1);
    drain("push_pop");

    // Randomised bytes, stop bits and consumer back-pressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      byte unsigned b;
      bit stop_ok;
      b = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 4) != 0);
      model_frame(b, stop_ok, 1'b0);
      send_frame(b, stop_ok);
      rx = 1'b1;
      repeat (BIT + $urandom_range(0, BIT)) @(negedge clk);
    end
    rand_ready = 1'b0;
    drain("random");
    checkpoint("random", 1'b1);

    // Reset in the middle of bit 4 of 0xFF.
    rx_ready = 1'b0;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset_valid", 32'(rx_valid), 32'd0);
    chk("midreset_level", 32'(level), 32'd0);
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_byte(8'h12);
    chk("midreset_level_after", 32'(level), 32'd1);
    checkpoint("midreset", 1'b1);
    drain("midreset");

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end that feeds the RISC-V core's UART peripheral from the board pin `UART_TXD_IN`. It synchronises the asynchronous line, detects and validates start bits using 16× oversampling, and deserialises 8N1 frames LSB first. Each good byte is pushed into a small first-word-fall-through FIFO, and the core drains it through a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses for the core's status register.

## Interface
- `CLK_FREQ`, 100_000_000: input clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DEPTH`, 8: FIFO depth in bytes; must be a power of two, ≥2.

- `clk`  in  1  system clock (CLK100MHZ domain).
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  raw serial line; idle high; asynchronous to `clk`.
- `rx_data`  out  8  byte at the FIFO head; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO is not empty.
- `rx_ready`  in  1  consumer accepts the head byte this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Synchroniser.** `rx` passes through 2 flip-flops to give `rx_s`. Both flops reset to 1.
- **Tick generator.**
  - `DIV = CLK_FREQ/(BAUD*16)`, integer floor; `DIV` = 54 at the default parameters.
  - A counter runs 0..DIV-1 and asserts `tick` for one cycle at DIV-1, then wraps.
  - It runs freely and is never re-phased by the receiver.
- **Receiver FSM.** A 4-bit sample counter `sc` advances on each `tick`. A 3-bit bit index `bi` tracks data bits.
  - IDLE: when `rx_s`=0, clear `sc` and go to START.
  - START: when `sc` reaches 7 on a `tick` (mid-bit):
    - if `rx_s`=0, clear `sc` and `bi`, go to DATA;
    - else treat as a glitch and return to IDLE.
  - DATA: when `sc` wraps 15→0, shift `rx_s` into `shreg[7]` (right shift, so the LSB arrives first).
    - If `bi`=7, go to STOP; else increment `bi`.
  - STOP: at the next 15→0 wrap, sample `rx_s`.
    - If 1: push `shreg`, go to IDLE.
    - If 0: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- **FIFO.**
  - Push on the stop-accept cycle; pop when `rx_valid && rx_ready`.
  - Full with push and no pop: drop the byte and pulse `overrun`; contents are unchanged.
  - Full with push and pop in the same cycle: both occur, no overrun, and `level` is unchanged.
  - Empty with pop requested: no pop, because `rx_valid`=0.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `level` is the count register, not derived from a pointer difference.
- **Reset values.**
  - `rx_valid`=0, `level`=0, `frame_err`=0, `overrun`=0, `rx_data`=0.
  - FSM returns to IDLE; all counters and pointers are cleared.
  - Reset asserted mid-frame abandons the frame; no partial byte is ever pushed.

## Timing
- Bit period = 16×DIV clocks (864 at the defaults).
- Start-edge detection lags the pin by 2–3 clocks because of the synchroniser.
- Data sampling: bit n is sampled 8+16(n+1) ticks after start detection (±1 tick of phase, since the tick counter is free-running).
- Push latency: `rx_valid` rises 1 clock after the stop-sample cycle. `rx_data` is the registered head (first-word-fall-through) and is stable while `rx_valid`=1 and no pop occurs.
- `rx_data` updates to the next entry 1 clock after a pop.
- `frame_err` and `overrun` are asserted in the cycle after the stop-sample cycle, for exactly 1 clock.

## Structure
- Package `uart_pkg` contains:
  - state enum `rx_state_t` {IDLE, START, DATA, STOP, BREAK};
  - constant `OVERSAMPLE`=16;
  - constant `MID_SAMPLE`=7.
- Sub-module `uart_fifo` (parameter `DEPTH`, width 8): push/pop/full/empty/count, first-word-fall-through. It is reused later by the transmit path.
- The tick generator and FSM stay inline in `uart_rx_fifo`.

## Test plan
- **Single byte.** Drive 0x55 as 8N1 at 864 clk/bit → `rx_valid`=1 with `rx_data`=0x55; after a pop, `level` returns to 0 and neither `frame_err` nor `overrun` pulses.
- **Glitch rejection.** Drive a 300-clk low pulse on an idle line → FSM returns to IDLE with no push and no `frame_err`; a following 0xA3 is received correctly.
- **Framing error.** Drive 0x3C with the stop bit low, then hold low for 3 bit times → exactly one `frame_err` pulse and nothing pushed; after the line returns high, 0x81 is received correctly.
- **Overrun.** Hold `rx_ready`=0 and send 9 bytes 0x00..0x08 → `level`=8, one `overrun` pulse on byte 9, and the drained sequence is 0x00..0x07.
- **Full with simultaneous push and pop.** With the FIFO full, assert `rx_ready` in the cycle a 10th byte 0xEE is pushed → no `overrun`, `level` stays 8, and 0xEE is drained last.
- **Reset mid-frame.** Assert `reset` low during bit 4 of 0xFF, release, then send 0x12 → only 0x12 appears and `level`=1.
